mask_row_serializer: RTL and testbench

// - Downstream of mask generation: captures the full-width row mask (mg_mask) when mg_valid is high.
// - Streams the captured row to the sensor mask-load interface as word_w-bit words under valid/ready.
// - Repeats capture+stream for image_sensor_h rows per frame, then signals frame_done.

---
 rtl/mask_stream_pkg.sv | 17 +
 rtl/mask_word_mux.sv | 28 ++
 rtl/mask_row_serializer.sv | 208 ++++++++++++++++++++
 tb/tb_mask_row_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_stream_pkg.sv
// Shared types and helpers for the row-mask serializer.
package mask_stream_pkg;

  localparam int unsigned DEFAULT_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MASK = 2'd1,
    STREAM    = 2'd2,
    DONE      = 2'd3
  } state_t;

  function automatic int unsigned num_words(input int unsigned w, input int unsigned word_w);
    return (w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/mask_word_mux.sv
// Selects word i_word_idx from a row mask; pixels at or beyond i_w_eff read as 0.
module mask_word_mux
  import mask_stream_pkg::*;
#(
  parameter int unsigned max_w  = 1920,
  parameter int unsigned word_w = DEFAULT_WORD_W,
  parameter int unsigned cnt_w  = 6,
  parameter int unsigned dim_w  = 11
) (
  input  logic [0:max_w-1]   i_shadow,
  input  logic [cnt_w-1:0]   i_word_idx,
  input  logic [dim_w-1:0]   i_w_eff,
  output logic [word_w-1:0]  o_word
);

  localparam int unsigned IDX_W = (max_w > 1) ? $clog2(max_w) : 1;

  // i_w_eff never exceeds max_w, so any pixel below it is a legal index
  always_comb begin
    o_word = '0;
    for (int unsigned j = 0; j < word_w; j++) begin
      int unsigned pix;
      pix = 32'(i_word_idx) * word_w + j;
      if (pix < 32'(i_w_eff)) o_word[j] = i_shadow[IDX_W'(pix)];
    end
  end

endmodule

// File: rtl/mask_row_serializer.sv
// Captures row masks from mask generation and streams them as words to the sensor mask-load port.
// Optional parity output enabled by defining MASK_SERIALIZER_PARITY_EN.
module mask_row_serializer
  import mask_stream_pkg::*;
#(
  parameter int unsigned max_image_sensor_w = 1920,
  parameter int unsigned max_image_sensor_h = 1080,
  parameter int unsigned word_w             = DEFAULT_WORD_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic [10:0]                   image_sensor_w,
  input  logic [10:0]                   image_sensor_h,
  input  logic                          start_frame,
  input  logic [0:max_image_sensor_w-1] mg_mask,
  input  logic                          mg_valid,
  output logic                          mask_ack,
  output logic [word_w-1:0]             out_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last_word,
  output logic                          out_last_row,
`ifdef MASK_SERIALIZER_PARITY_EN
  output logic                          out_parity,
`endif
  output logic [10:0]                   row_idx,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int unsigned DIM_W  = 11;
  localparam int unsigned NW_MAX = num_words(max_image_sensor_w, word_w);
  localparam int unsigned CNT_W  = $clog2(NW_MAX + 1);

  state_t                        r_state, w_state_nxt;
  logic [DIM_W-1:0]              r_w_eff, w_w_eff_nxt;
  logic [DIM_W-1:0]              r_h, w_h_nxt;
  logic [DIM_W-1:0]              r_row_cnt, w_row_cnt_nxt;
  logic [CNT_W-1:0]              r_last_idx, w_last_idx_nxt;
  logic [CNT_W-1:0]              r_word_cnt, w_word_cnt_nxt;
  logic [0:max_image_sensor_w-1] r_shadow, w_shadow_nxt;
  logic [word_w-1:0]             r_out_word, w_out_word_nxt;
  logic                          r_out_valid, w_out_valid_nxt;
  logic                          r_out_last_word, w_out_last_word_nxt;
  logic                          r_out_last_row, w_out_last_row_nxt;
  logic                          r_mask_ack, w_mask_ack_nxt;
  logic                          r_busy, w_busy_nxt;
  logic                          r_frame_done, w_frame_done_nxt;

  logic [DIM_W-1:0]              w_w_in, w_h_in;
  logic [CNT_W-1:0]              w_last_in;
  logic                          w_capture, w_row_last, w_word_last;
  logic [0:max_image_sensor_w-1] w_mux_src;
  logic [CNT_W-1:0]              w_mux_idx;
  logic [word_w-1:0]             w_mux_word;

  // Requested geometry is clamped to the hardware maximum when latched
  assign w_w_in = (image_sensor_w > DIM_W'(max_image_sensor_w)) ? DIM_W'(max_image_sensor_w)
                                                                 : image_sensor_w;
  assign w_h_in = (image_sensor_h > DIM_W'(max_image_sensor_h)) ? DIM_W'(max_image_sensor_h)
                                                                 : image_sensor_h;
  assign w_last_in = CNT_W'(num_words(32'(w_w_in), word_w) - 1);

  assign w_capture   = (r_state == WAIT_MASK) && mg_valid;
  assign w_row_last  = (r_row_cnt == (r_h - DIM_W'(1)));
  assign w_word_last = (r_word_cnt == r_last_idx);

  // On capture, word 0 is taken straight from mg_mask so it is valid the next cycle
  assign w_mux_src = w_capture ? mg_mask : r_shadow;
  assign w_mux_idx = w_capture ? '0 : (r_word_cnt + CNT_W'(1));

  mask_word_mux #(
    .max_w  (max_image_sensor_w),
    .word_w (word_w),
    .cnt_w  (CNT_W),
    .dim_w  (DIM_W)
  ) u_word_mux (
    .i_shadow   (w_mux_src),
    .i_word_idx (w_mux_idx),
    .i_w_eff    (r_w_eff),
    .o_word     (w_mux_word)
  );

  always_comb begin
    w_state_nxt         = r_state;
    w_w_eff_nxt         = r_w_eff;
    w_h_nxt             = r_h;
    w_last_idx_nxt      = r_last_idx;
    w_word_cnt_nxt      = r_word_cnt;
    w_row_cnt_nxt       = r_row_cnt;
    w_shadow_nxt        = r_shadow;
    w_out_word_nxt      = r_out_word;
    w_out_valid_nxt     = r_out_valid;
    w_out_last_word_nxt = r_out_last_word;
    w_out_last_row_nxt  = r_out_last_row;
    w_mask_ack_nxt      = 1'b0;
    w_busy_nxt          = r_busy;
    w_frame_done_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_frame) begin
          w_busy_nxt     = 1'b1;
          w_w_eff_nxt    = w_w_in;
          w_h_nxt        = w_h_in;
          w_last_idx_nxt = w_last_in;
          w_row_cnt_nxt  = '0;
          w_state_nxt    = ((w_w_in == '0) || (w_h_in == '0)) ? DONE : WAIT_MASK;
        end
      end
      WAIT_MASK: begin
        if (mg_valid) begin
          w_shadow_nxt        = mg_mask;
          w_mask_ack_nxt      = 1'b1;
          w_word_cnt_nxt      = '0;
          w_out_valid_nxt     = 1'b1;
          w_out_word_nxt      = w_mux_word;
          w_out_last_word_nxt = (r_last_idx == '0);
          w_out_last_row_nxt  = w_row_last;
          w_state_nxt         = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (w_word_last) begin
            w_out_valid_nxt     = 1'b0;
            w_out_word_nxt      = '0;
            w_out_last_word_nxt = 1'b0;
            w_out_last_row_nxt  = 1'b0;
            if (w_row_last) begin
              w_state_nxt = DONE;
            end else begin
              w_row_cnt_nxt = r_row_cnt + DIM_W'(1);
              w_state_nxt   = WAIT_MASK;
            end
          end else begin
            w_word_cnt_nxt      = w_mux_idx;
            w_out_word_nxt      = w_mux_word;
            w_out_last_word_nxt = (w_mux_idx == r_last_idx);
          end
        end
      end
      DONE: begin
        w_busy_nxt       = 1'b0;
        w_frame_done_nxt = 1'b1;
        w_state_nxt      = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // clk_en low freezes every register, so out_ready cannot complete a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_w_eff         <= '0;
      r_h             <= '0;
      r_last_idx      <= '0;
      r_word_cnt      <= '0;
      r_row_cnt       <= '0;
      r_shadow        <= '0;
      r_out_word      <= '0;
      r_out_valid     <= 1'b0;
      r_out_last_word <= 1'b0;
      r_out_last_row  <= 1'b0;
      r_mask_ack      <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_done    <= 1'b0;
    end else if (clk_en) begin
      r_state         <= w_state_nxt;
      r_w_eff         <= w_w_eff_nxt;
      r_h             <= w_h_nxt;
      r_last_idx      <= w_last_idx_nxt;
      r_word_cnt      <= w_word_cnt_nxt;
      r_row_cnt       <= w_row_cnt_nxt;
      r_shadow        <= w_shadow_nxt;
      r_out_word      <= w_out_word_nxt;
      r_out_valid     <= w_out_valid_nxt;
      r_out_last_word <= w_out_last_word_nxt;
      r_out_last_row  <= w_out_last_row_nxt;
      r_mask_ack      <= w_mask_ack_nxt;
      r_busy          <= w_busy_nxt;
      r_frame_done    <= w_frame_done_nxt;
    end
  end

`ifdef MASK_SERIALIZER_PARITY_EN
  logic r_out_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_out_parity <= 1'b0;
    else if (clk_en) r_out_parity <= ^w_out_word_nxt;
  end

  assign out_parity = r_out_parity;
`endif

  assign mask_ack      = r_mask_ack;
  assign out_word      = r_out_word;
  assign out_valid     = r_out_valid;
  assign out_last_word = r_out_last_word;
  assign out_last_row  = r_out_last_row;
  assign row_idx       = r_row_cnt;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_mask_row_serializer.sv
// Directed bench for mask_row_serializer (define MASK_SERIALIZER_PARITY_EN to cover parity).
module tb_mask_row_serializer;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic [10:0]   image_sensor_w;
  logic [10:0]   image_sensor_h;
  logic          start_frame;
  logic [0:1919] mg_mask;
  logic          mg_valid;
  logic          mask_ack;
  logic [31:0]   out_word;
  logic          out_valid;
  logic          out_ready;
  logic          out_last_word;
  logic          out_last_row;
  logic [10:0]   row_idx;
  logic          busy;
  logic          frame_done;
`ifdef MASK_SERIALIZER_PARITY_EN
  logic          out_parity;
`endif

  int n_run  = 0;
  int n_fail = 0;

  // Per-frame observations filled by collect()
  int          n_cap, first_valid, done_cycle, busy_cycles, stall_changes, ack_count;
  logic        timed_out;
  logic [31:0] cap_word [16];
  logic [15:0] cap_lw, cap_lr, cap_row0, cap_par;

  // Hand bit-reversals of the 64-bit test pattern (pixel 0 = leftmost hex bit)
  localparam logic [31:0] PAT_W0 = 32'h0000_A5A5;
  localparam logic [31:0] PAT_W1 = 32'h2C48_FFFF;

  mask_row_serializer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .image_sensor_w (image_sensor_w),
    .image_sensor_h (image_sensor_h),
    .start_frame    (start_frame),
    .mg_mask        (mg_mask),
    .mg_valid       (mg_valid),
    .mask_ack       (mask_ack),
    .out_word       (out_word),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last_word  (out_last_word),
    .out_last_row   (out_last_row),
`ifdef MASK_SERIALIZER_PARITY_EN
    .out_parity     (out_parity),
`endif
    .row_idx        (row_idx),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic record();
    if (n_cap < 16) begin
      cap_word[n_cap] = out_word;
      cap_lw[n_cap]   = out_last_word;
      cap_lr[n_cap]   = out_last_row;
      cap_row0[n_cap] = row_idx[0];
`ifdef MASK_SERIALIZER_PARITY_EN
      cap_par[n_cap]  = out_parity;
`endif
    end
    n_cap++;
  endtask

  // Starts a frame and records accepted words until frame_done or the cycle budget runs out
  task automatic collect(input int stall_after, input int stall_len, input bit clear_after_first);
    int          stall_left;
    bit          stalled;
    logic [31:0] prev_word;
    logic [10:0] prev_row;
    n_cap = 0; first_valid = -1; done_cycle = -1; busy_cycles = 0;
    stall_changes = 0; ack_count = 0; timed_out = 1'b1;
    cap_lw = '0; cap_lr = '0; cap_row0 = '0; cap_par = '0;
    stall_left = 0; stalled = 1'b0; prev_word = '0; prev_row = '0;
    out_ready = 1'b1;
    @(negedge clk);
    start_frame = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start_frame = 1'b0;
      if (frame_done) begin
        done_cycle = cyc;
        timed_out  = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
      if (mask_ack) ack_count++;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (!stalled && stall_len > 0 && n_cap == stall_after) begin
          stalled    = 1'b1;
          stall_left = stall_len;
          prev_word  = out_word;
          prev_row   = row_idx;
          out_ready  = 1'b0;
        end else if (stall_left > 0) begin
          if (out_word !== prev_word || row_idx !== prev_row) stall_changes++;
          stall_left--;
          if (stall_left == 0) begin
            out_ready = 1'b1;
            record();
          end
        end else begin
          record();
          if (clear_after_first && n_cap == 1) mg_mask = '0;
        end
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; start_frame = 1'b0; mg_valid = 1'b0; out_ready = 1'b1;
    image_sensor_w = '0; image_sensor_h = '0; mg_mask = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_run++; if (out_word !== 32'h0) begin n_fail++; $display("FAIL reset_out_word: got %h want 0", out_word); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_run++; if (frame_done !== 1'b0 || mask_ack !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b ack=%b want 0", frame_done, mask_ack); end
    n_run++; if (row_idx !== 11'd0 || out_last_word !== 1'b0 || out_last_row !== 1'b0) begin
      n_fail++; $display("FAIL reset_row_flags: got row=%0d lw=%b lr=%b want 0", row_idx, out_last_word, out_last_row); end
  endtask

  task automatic test_two_rows();
    image_sensor_w = 11'd64; image_sensor_h = 11'd2;
    mg_mask = '0; mg_mask[0:63] = 64'hA5A5_0000_FFFF_1234; mg_valid = 1'b1;
    collect(-1, 0, 1'b0);
    mg_valid = 1'b0;
    n_run++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL two_rows_timeout: no frame_done"); end
    n_run++; if (n_cap !== 4) begin n_fail++; $display("FAIL two_rows_count: got %0d want 4", n_cap); end
    n_run++; if (cap_word[0] !== PAT_W0 || cap_word[2] !== PAT_W0) begin
      n_fail++; $display("FAIL two_rows_word0: got %h/%h want %h", cap_word[0], cap_word[2], PAT_W0); end
    n_run++; if (cap_word[1] !== PAT_W1 || cap_word[3] !== PAT_W1) begin
      n_fail++; $display("FAIL two_rows_word1: got %h/%h want %h", cap_word[1], cap_word[3], PAT_W1); end
    n_run++; if (cap_lw[3:0] !== 4'b1010) begin n_fail++; $display("FAIL two_rows_last_word: got %b want 1010", cap_lw[3:0]); end
    n_run++; if (cap_lr[3:0] !== 4'b1100) begin n_fail++; $display("FAIL two_rows_last_row: got %b want 1100", cap_lr[3:0]); end
    n_run++; if (cap_row0[3:0] !== 4'b1100) begin n_fail++; $display("FAIL two_rows_row_idx: got %b want 1100", cap_row0[3:0]); end
    n_run++; if (first_valid !== 2) begin n_fail++; $display("FAIL two_rows_latency: got %0d want 2", first_valid); end
    n_run++; if (done_cycle !== 8) begin n_fail++; $display("FAIL two_rows_done_cycle: got %0d want 8", done_cycle); end
    n_run++; if (ack_count !== 2) begin n_fail++; $display("FAIL two_rows_mask_ack: got %0d want 2", ack_count); end
    n_run++; if (busy_cycles !== 7 || busy !== 1'b0) begin
      n_fail++; $display("FAIL two_rows_busy: got %0d cycles busy_now=%b want 7 and 0", busy_cycles, busy); end
  endtask

  task automatic test_partial_word();
    image_sensor_w = 11'd40; image_sensor_h = 11'd1;
    mg_mask = '1; mg_valid = 1'b1;
    collect(-1, 0, 1'b1);
    mg_valid = 1'b0;
    n_run++; if (timed_out !== 1'b0 || n_cap !== 2) begin n_fail++; $display("FAIL w40_count: got %0d timeout=%b want 2", n_cap, timed_out); end
    n_run++; if (cap_word[0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL w40_word0: got %h want ffffffff", cap_word[0]); end
    n_run++; if (cap_word[1] !== 32'h0000_00FF) begin n_fail++; $display("FAIL w40_word1: got %h want 000000ff", cap_word[1]); end
    n_run++; if (cap_lw[1:0] !== 2'b10 || cap_lr[1:0] !== 2'b11) begin
      n_fail++; $display("FAIL w40_flags: got lw=%b lr=%b want 10 11", cap_lw[1:0], cap_lr[1:0]); end
    n_run++; if (done_cycle !== 5) begin n_fail++; $display("FAIL w40_done_cycle: got %0d want 5", done_cycle); end
  endtask

  task automatic test_backpressure();
    image_sensor_w = 11'd64; image_sensor_h = 11'd2;
    mg_mask = '0; mg_mask[0:63] = 64'hA5A5_0000_FFFF_1234; mg_valid = 1'b1;
    collect(1, 5, 1'b0);
    mg_valid = 1'b0;
    n_run++; if (stall_changes !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", stall_changes); end
    n_run++; if (n_cap !== 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", n_cap); end
    n_run++; if (cap_word[0] !== PAT_W0 || cap_word[1] !== PAT_W1 || cap_word[2] !== PAT_W0 || cap_word[3] !== PAT_W1) begin
      n_fail++; $display("FAIL bp_order: got %h %h %h %h", cap_word[0], cap_word[1], cap_word[2], cap_word[3]); end
    n_run++; if (done_cycle !== 13) begin n_fail++; $display("FAIL bp_done_cycle: got %0d want 13", done_cycle); end
  endtask

  task automatic test_zero_geometry();
    image_sensor_w = 11'd0; image_sensor_h = 11'd3; mg_valid = 1'b1; mg_mask = '1;
    @(negedge clk);
    start_frame = 1'b1;
    @(negedge clk);
    // Still asserted during the DONE cycle, where it must be ignored
    n_run++; if (busy !== 1'b1 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL w0_cycle1: got busy=%b ov=%b fd=%b want 1 0 0", busy, out_valid, frame_done); end
    @(negedge clk);
    start_frame = 1'b0;
    n_run++; if (frame_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL w0_cycle2: got fd=%b busy=%b want 1 0", frame_done, busy); end
    @(negedge clk);
    n_run++; if (busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL w0_start_in_done: got busy=%b fd=%b want 0 0", busy, frame_done); end
    image_sensor_w = 11'd64; image_sensor_h = 11'd0;
    collect(-1, 0, 1'b0);
    mg_valid = 1'b0;
    n_run++; if (first_valid !== -1 || done_cycle !== 2 || busy_cycles !== 1) begin
      n_fail++; $display("FAIL h0_frame: got first_valid=%0d done=%0d busy=%0d want -1 2 1", first_valid, done_cycle, busy_cycles); end
  endtask

  task automatic test_clk_en_reset();
    bit seen;
    int fd_cnt, ov_cnt;
    image_sensor_w = 11'd96; image_sensor_h = 11'd1;
    mg_mask = '0; mg_mask[0:63] = 64'hA5A5_0000_FFFF_1234; mg_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_run++; if (!seen) begin n_fail++; $display("FAIL ce_first_word: out_valid never rose"); end
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    n_run++; if (out_word !== PAT_W0 || out_valid !== 1'b1 || row_idx !== 11'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ce_freeze: got word=%h ov=%b row=%0d busy=%b want %h 1 0 1", out_word, out_valid, row_idx, busy, PAT_W0); end
    clk_en = 1'b1;
    @(negedge clk);
    n_run++; if (out_word !== PAT_W1 || out_last_word !== 1'b0) begin
      n_fail++; $display("FAIL ce_resume: got word=%h lw=%b want %h 0", out_word, out_last_word, PAT_W1); end
    rst_n = 1'b0;
    #1;
    n_run++; if ({out_valid, busy, frame_done, mask_ack, out_last_word, out_last_row} !== 6'b0 || out_word !== 32'h0 || row_idx !== 11'd0) begin
      n_fail++; $display("FAIL rst_mid_row: got ov=%b busy=%b word=%h row=%0d want all 0", out_valid, busy, out_word, row_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    fd_cnt = 0; ov_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (out_valid) ov_cnt++;
    end
    mg_valid = 1'b0;
    n_run++; if (fd_cnt !== 0 || ov_cnt !== 0) begin
      n_fail++; $display("FAIL rst_no_done: got frame_done=%0d out_valid=%0d want 0 0", fd_cnt, ov_cnt); end
  endtask

`ifdef MASK_SERIALIZER_PARITY_EN
  task automatic test_parity();
    image_sensor_w = 11'd32; image_sensor_h = 11'd1; mg_valid = 1'b1;
    mg_mask = '0; mg_mask[0:2] = 3'b111;
    collect(-1, 0, 1'b0);
    n_run++; if (cap_word[0] !== 32'h7 || cap_par[0] !== 1'b1) begin
      n_fail++; $display("FAIL parity_odd: got word=%h par=%b want 7 1", cap_word[0], cap_par[0]); end
    mg_mask = '0; mg_mask[0:1] = 2'b11;
    collect(-1, 0, 1'b0);
    mg_valid = 1'b0;
    n_run++; if (cap_word[0] !== 32'h3 || cap_par[0] !== 1'b0) begin
      n_fail++; $display("FAIL parity_even: got word=%h par=%b want 3 0", cap_word[0], cap_par[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_rows();
    test_partial_word();
    test_backpressure();
    test_zero_geometry();
    test_clk_en_reset();
`ifdef MASK_SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
